// File: rtl/lc3_regfile_banked.sv
// Banked LC-3 register file: NREG x WIDTH, two combinational read ports, one write port, busy scoreboard.
// Latency: reads and the optional write bypass are combinational; writes, busy and swap state update on the Clk edge.
// Backpressure: SWAP_BUSY marks a stack-pointer swap in progress; new swap requests are ignored while it is high.
module lc3_regfile_banked #(
    parameter int               WIDTH    = 16,
    parameter int               NREG     = 8,
    parameter int               AW       = $clog2(NREG),
    parameter int               SP_INDEX = 6,
    parameter logic [WIDTH-1:0] SSP_INIT = WIDTH'(16'h3000),
    parameter int               BYPASS   = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_REG,
    input  logic [AW-1:0]    DR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic [AW-1:0]    SR1_ADDR,
    input  logic [AW-1:0]    SR2_ADDR,
    output logic [WIDTH-1:0] SR1_OUT,
    output logic [WIDTH-1:0] SR2_OUT,
    input  logic             ISSUE,
    input  logic [AW-1:0]    ISSUE_ADDR,
    output logic             SR1_BUSY,
    output logic             SR2_BUSY,
    input  logic             SWAP_REQ,
    input  logic             SWAP_TO_SUP,
    output logic             SWAP_BUSY,
    output logic             SUP_MODE
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAVE, S_LOAD} swap_state_t;

    localparam logic [AW-1:0] SP_A = AW'(SP_INDEX);

    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  busy;
    logic [WIDTH-1:0] usp_save;
    logic [WIDTH-1:0] ssp_save;
    logic             sup_mode;
    swap_state_t      state;
    swap_state_t      state_nxt;

    logic xfer;
    logic wr_en;
    logic iss_en;
    logic hit1;
    logic hit2;

    // While the SP is being saved/loaded, the swap owns R[SP]: external writes and claims to it are dropped.
    assign xfer   = (state == S_SAVE) || (state == S_LOAD);
    assign wr_en  = LD_REG && !(xfer && (DR_ADDR == SP_A));
    assign iss_en = ISSUE && !(xfer && (ISSUE_ADDR == SP_A));

    // Only a write that will really land is forwarded, so a dropped SP write never shows on a read port.
    assign hit1 = (BYPASS != 0) && wr_en && (DR_ADDR == SR1_ADDR);
    assign hit2 = (BYPASS != 0) && wr_en && (DR_ADDR == SR2_ADDR);

    assign SR1_OUT   = hit1 ? WR_DATA : regs[SR1_ADDR];
    assign SR2_OUT   = hit2 ? WR_DATA : regs[SR2_ADDR];
    assign SR1_BUSY  = hit1 ? 1'b0 : busy[SR1_ADDR];
    assign SR2_BUSY  = hit2 ? 1'b0 : busy[SR2_ADDR];
    assign SWAP_BUSY = (state != S_IDLE);
    assign SUP_MODE  = sup_mode;

    // Swap sequencing: accept a real mode change, wait out a pending SP writer, then save and load.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (SWAP_REQ && (SWAP_TO_SUP != sup_mode))
                        state_nxt = busy[SP_A] ? S_WAIT : S_SAVE;
            S_WAIT: if (!busy[SP_A]) state_nxt = S_SAVE;
            S_SAVE: state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Swap state register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Register array, scoreboard and banked stack pointers; the target mode is always the opposite of sup_mode.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy     <= '0;
            usp_save <= '0;
            ssp_save <= SSP_INIT;
            sup_mode <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[DR_ADDR] <= WR_DATA;
                busy[DR_ADDR] <= 1'b0;
            end
            // Placed after the clear so a same-cycle claim on the written register keeps it busy.
            if (iss_en) busy[ISSUE_ADDR] <= 1'b1;
            if (state == S_SAVE) begin
                if (!sup_mode) usp_save <= regs[SP_A];
                else           ssp_save <= regs[SP_A];
            end
            if (state == S_LOAD) begin
                regs[SP_A] <= sup_mode ? usp_save : ssp_save;
                sup_mode   <= ~sup_mode;
            end
        end
    end

endmodule
